// File: rtl/regwb_arbiter.sv
// Write-back arbiter for the MIPS register file. It shares the single write port between
// two requesters round-robin and keeps a pending-write scoreboard for read-hazard detection.
module regwb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                   WBA_clk,
  input  logic                   WBA_rst,
  input  logic                   WBA_a_valid,
  output logic                   WBA_a_ready,
  input  logic [ADDR_W-1:0]      WBA_a_addr,
  input  logic [DATA_W-1:0]      WBA_a_data,
  input  logic                   WBA_b_valid,
  output logic                   WBA_b_ready,
  input  logic [ADDR_W-1:0]      WBA_b_addr,
  input  logic [DATA_W-1:0]      WBA_b_data,
  input  logic                   WBA_rsv_en,
  input  logic [ADDR_W-1:0]      WBA_rsv_addr,
  input  logic [ADDR_W-1:0]      WBA_rd_addr1,
  input  logic [ADDR_W-1:0]      WBA_rd_addr2,
  output logic                   WBA_busy1,
  output logic                   WBA_busy2,
  output logic                   WBA_wr_en,
  output logic [ADDR_W-1:0]      WBA_wr_addr,
  output logic [DATA_W-1:0]      WBA_wr_data,
  output logic [(2**ADDR_W)-1:0] WBA_pending,
  output logic [CNT_W-1:0]       WBA_conflict_cnt
);

  typedef enum logic {GNT_A, GNT_B} gnt_e;

  gnt_e                   last_gnt;
  logic                   contended;
  logic                   take_a;
  logic                   take_b;
  logic [(2**ADDR_W)-1:0] pending_nxt;

  assign contended = WBA_a_valid & WBA_b_valid;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    take_a = 1'b0;
    take_b = 1'b0;
    if (!WBA_rst) begin
      if (contended) begin
        take_a = (last_gnt == GNT_B);
        take_b = (last_gnt == GNT_A);
      end else begin
        take_a = WBA_a_valid;
        take_b = WBA_b_valid;
      end
    end
  end

  assign WBA_a_ready = take_a;
  assign WBA_b_ready = take_b;

  // The set is applied after the clear, so a younger reservation owns the register.
  always_comb begin
    pending_nxt = WBA_pending;
    if (WBA_wr_en) pending_nxt[WBA_wr_addr] = 1'b0;
    if (WBA_rsv_en) pending_nxt[WBA_rsv_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  assign WBA_busy1 = WBA_pending[WBA_rd_addr1];
  assign WBA_busy2 = WBA_pending[WBA_rd_addr2];

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race readers.
  always_ff @(posedge WBA_clk) begin
    if (WBA_rst) begin
      last_gnt         <= GNT_B;
      WBA_wr_en        <= 1'b0;
      WBA_wr_addr      <= '0;
      WBA_wr_data      <= '0;
      WBA_pending      <= '0;
      WBA_conflict_cnt <= '0;
    end else begin
      if (contended) last_gnt <= take_a ? GNT_A : GNT_B;
      // Writes to $0 are accepted but never reach the register file.
      WBA_wr_en <= (take_a && (WBA_a_addr != '0)) || (take_b && (WBA_b_addr != '0));
      if (take_a) begin
        WBA_wr_addr <= WBA_a_addr;
        WBA_wr_data <= WBA_a_data;
      end else if (take_b) begin
        WBA_wr_addr <= WBA_b_addr;
        WBA_wr_data <= WBA_b_data;
      end
      WBA_pending <= pending_nxt;
      if (contended && (WBA_conflict_cnt != '1))
        WBA_conflict_cnt <= WBA_conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regwb_arbiter.sv
// Bench for regwb_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the grant rules, scoreboard, counter and an attached register file.
module tb_regwb_arbiter;
  localparam int NREG = 32;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, a_valid, b_valid, rsv_en;
  logic [4:0]  a_addr, b_addr, rsv_addr, rd_addr1, rd_addr2;
  logic [31:0] a_data, b_data;

  logic        a_ready, b_ready, busy1, busy2, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, pending;
  logic [15:0] cnt;

  logic        s_a_ready, s_b_ready, s_busy1, s_busy2, s_wr_en;
  logic [4:0]  s_wr_addr;
  logic [31:0] s_wr_data, s_pending;
  logic [3:0]  s_cnt;

  regwb_arbiter dut (
    .WBA_clk(clk), .WBA_rst(rst),
    .WBA_a_valid(a_valid), .WBA_a_ready(a_ready), .WBA_a_addr(a_addr), .WBA_a_data(a_data),
    .WBA_b_valid(b_valid), .WBA_b_ready(b_ready), .WBA_b_addr(b_addr), .WBA_b_data(b_data),
    .WBA_rsv_en(rsv_en), .WBA_rsv_addr(rsv_addr),
    .WBA_rd_addr1(rd_addr1), .WBA_rd_addr2(rd_addr2),
    .WBA_busy1(busy1), .WBA_busy2(busy2),
    .WBA_wr_en(wr_en), .WBA_wr_addr(wr_addr), .WBA_wr_data(wr_data),
    .WBA_pending(pending), .WBA_conflict_cnt(cnt)
  );

  regwb_arbiter #(.CNT_W(4)) dut_sat (
    .WBA_clk(clk), .WBA_rst(rst),
    .WBA_a_valid(a_valid), .WBA_a_ready(s_a_ready), .WBA_a_addr(a_addr), .WBA_a_data(a_data),
    .WBA_b_valid(b_valid), .WBA_b_ready(s_b_ready), .WBA_b_addr(b_addr), .WBA_b_data(b_data),
    .WBA_rsv_en(rsv_en), .WBA_rsv_addr(rsv_addr),
    .WBA_rd_addr1(rd_addr1), .WBA_rd_addr2(rd_addr2),
    .WBA_busy1(s_busy1), .WBA_busy2(s_busy2),
    .WBA_wr_en(s_wr_en), .WBA_wr_addr(s_wr_addr), .WBA_wr_data(s_wr_data),
    .WBA_pending(s_pending), .WBA_conflict_cnt(s_cnt)
  );

  // Register file attached to the write port; it writes whatever the arbiter issues.
  logic [31:0] rf [NREG];
  always @(posedge clk) if (wr_en === 1'b1) rf[wr_addr] <= wr_data;

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    return rf[a];
  endfunction

  // Reference model state.
  bit          m_pend [NREG];
  bit          m_last_a;
  int          m_cnt;
  bit          m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  logic [31:0] m_rf [NREG];

  int total = 0;
  int bad   = 0;

  function automatic bit win_a();
    if (rst || !a_valid) return 1'b0;
    return !b_valid || !m_last_a;
  endfunction

  function automatic bit win_b();
    if (rst || !b_valid) return 1'b0;
    return !a_valid || m_last_a;
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic int m_cnt_sat(input int lim);
    return (m_cnt > lim) ? lim : m_cnt;
  endfunction

  // Advance the model by one rising edge using the inputs held this cycle, then cross the edge.
  task automatic step();
    bit ga, gb;
    ga = win_a();
    gb = win_b();
    if (m_wr_en) m_rf[m_wr_addr] = m_wr_data;
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_last_a  = 1'b0;
      m_cnt     = 0;
      m_wr_en   = 1'b0;
      m_wr_addr = '0;
      m_wr_data = '0;
    end else begin
      if (m_wr_en) m_pend[m_wr_addr] = 1'b0;
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
      if (a_valid && b_valid) begin
        m_cnt++;
        m_last_a = ga;
      end
      if (ga) begin
        m_wr_en = (a_addr != 0); m_wr_addr = a_addr; m_wr_data = a_data;
      end else if (gb) begin
        m_wr_en = (b_addr != 0); m_wr_addr = b_addr; m_wr_data = b_data;
      end else begin
        m_wr_en = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; rsv_en = 1'b0;
    a_addr = 5'd1; b_addr = 5'd2; rsv_addr = 5'd0; rd_addr1 = 5'd3; rd_addr2 = 5'd4;
    a_data = 32'h0; b_data = 32'h0;
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rst_a_ready: got %b want 0", a_ready); end
      total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL rst_b_ready: got %b want 0", b_ready); end
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
      total++; if (pending !== 32'h0) begin bad++; $display("FAIL rst_pending: got %h want 0", pending); end
      total++; if (cnt !== 16'h0 || s_cnt !== 4'h0) begin bad++; $display("FAIL rst_cnt: got %h/%h want 0", cnt, s_cnt); end
      total++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b%b want 00", busy1, busy2); end
      total++; if (wr_addr !== 5'h0 || wr_data !== 32'h0) begin bad++; $display("FAIL rst_wr_bus: got %h/%h want 0", wr_addr, wr_data); end
      step();
    end
  endtask

  task automatic test_single_write();
    bit exp_busy;
    rd_addr1 = 5'd5; rd_addr2 = 5'd0;
    for (int c = 0; c <= 5; c++) begin
      idle();
      rsv_en = (c == 0); rsv_addr = 5'd5;
      a_valid = (c == 3); a_addr = 5'd5; a_data = 32'hDEADBEEF;
      @(negedge clk);
      exp_busy = (c >= 1 && c <= 4);
      total++; if (busy1 !== exp_busy) begin bad++; $display("FAIL sw_busy1 c%0d: got %b want %b", c, busy1, exp_busy); end
      total++; if (wr_en !== (c == 4)) begin bad++; $display("FAIL sw_wr_en c%0d: got %b want %b", c, wr_en, c == 4); end
      if (c == 3) begin
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL sw_a_ready: got %b want 1", a_ready); end
      end
      if (c == 4) begin
        total++; if (wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wr_bus: got %h/%h want 05/deadbeef", wr_addr, wr_data); end
      end
      if (c == 5) begin
        total++; if (rf_read(rd_addr1) !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_rf_read: got %h want deadbeef", rf_read(rd_addr1)); end
      end
      step();
    end
  endtask

  task automatic test_contention();
    logic [31:0] da [4];
    logic [31:0] db [4];
    logic [31:0] exp_d;
    foreach (da[i]) begin da[i] = $urandom; db[i] = $urandom; end
    idle(); rsv_en = 1'b1; rsv_addr = 5'd1; step();
    rsv_addr = 5'd2; step();
    for (int c = 0; c <= 5; c++) begin
      idle();
      a_valid = (c < 4); b_valid = (c < 4);
      a_addr = 5'd1; b_addr = 5'd2;
      a_data = da[c % 4]; b_data = db[c % 4];
      @(negedge clk);
      total++; if (a_ready !== (c < 4 && c % 2 == 0)) begin bad++; $display("FAIL ct_a_ready c%0d: got %b", c, a_ready); end
      total++; if (b_ready !== (c < 4 && c % 2 == 1)) begin bad++; $display("FAIL ct_b_ready c%0d: got %b", c, b_ready); end
      total++; if (wr_en !== (c >= 1 && c <= 4)) begin bad++; $display("FAIL ct_wr_en c%0d: got %b", c, wr_en); end
      if (c >= 1 && c <= 4) begin
        exp_d = ((c - 1) % 2 == 0) ? da[c - 1] : db[c - 1];
        total++; if (wr_addr !== (((c - 1) % 2 == 0) ? 5'd1 : 5'd2) || wr_data !== exp_d) begin
          bad++; $display("FAIL ct_wr_bus c%0d: got %h/%h want data %h", c, wr_addr, wr_data, exp_d);
        end
      end
      if (c == 5) begin
        total++; if (cnt !== 16'd4 || s_cnt !== 4'd4) begin bad++; $display("FAIL ct_cnt: got %0d/%0d want 4", cnt, s_cnt); end
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL ct_pending: got %h want 0", pending); end
      end
      step();
    end
  endtask

  task automatic test_reg0();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd0;
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h1234;
    rd_addr1 = 5'd0;
    @(negedge clk);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL r0_a_ready: got %b want 1", a_ready); end
    step();
    idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL r0_wr_en c%0d: got %b want 0", c, wr_en); end
      total++; if (pending[0] !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL r0_pending0: got %b/%b want 0", pending[0], busy1); end
      total++; if (rf_read(rd_addr1) !== 32'h0) begin bad++; $display("FAIL r0_rf_read: got %h want 0", rf_read(rd_addr1)); end
      step();
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    rd_addr1 = 5'd7;
    for (int c = 0; c <= 5; c++) begin
      idle();
      rsv_en = (c == 0 || c == 2); rsv_addr = 5'd7;
      a_valid = (c == 1 || c == 3); a_addr = 5'd7; a_data = (c == 1) ? d1 : d2;
      @(negedge clk);
      if (c == 2) begin
        total++; if (wr_en !== 1'b1 || wr_addr !== 5'd7) begin bad++; $display("FAIL sc_issue: got %b/%h want 1/07", wr_en, wr_addr); end
      end
      if (c == 3) begin
        total++; if (pending[7] !== 1'b1 || busy1 !== 1'b1) begin bad++; $display("FAIL sc_set_wins: got %b/%b want 1", pending[7], busy1); end
      end
      if (c == 5) begin
        total++; if (pending[7] !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL sc_cleared: got %b/%b want 0", pending[7], busy1); end
        total++; if (rf_read(rd_addr1) !== d2) begin bad++; $display("FAIL sc_rf_read: got %h want %h", rf_read(rd_addr1), d2); end
      end
      step();
    end
  endtask

  task automatic test_saturation();
    int exp_s;
    for (int c = 0; c <= 20; c++) begin
      idle();
      a_valid = (c < 20); b_valid = (c < 20);
      a_addr = 5'd3; b_addr = 5'd4; a_data = $urandom; b_data = $urandom;
      @(negedge clk);
      exp_s = (4 + c > 15) ? 15 : 4 + c;
      total++; if (s_cnt !== 4'(exp_s)) begin bad++; $display("FAIL sat_cnt4 c%0d: got %0d want %0d", c, s_cnt, exp_s); end
      total++; if (cnt !== 16'(4 + c)) begin bad++; $display("FAIL sat_cnt16 c%0d: got %0d want %0d", c, cnt, 4 + c); end
      step();
    end
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c <= 5; c++) begin
      idle();
      rsv_en = (c == 0 || c == 2); rsv_addr = (c == 0) ? 5'd11 : 5'd10;
      a_addr = 5'd9; b_addr = 5'd12; a_data = $urandom; b_data = $urandom;
      a_valid = (c == 0 || c == 2 || c == 4);
      b_valid = (c <= 2 || c == 4);
      rst = (c == 2);
      @(negedge clk);
      if (c == 1) begin
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL mr_b_ready: got %b want 1", b_ready); end
      end
      if (c == 2) begin
        total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++; $display("FAIL mr_ready_in_rst: got %b%b want 00", a_ready, b_ready); end
        total++; if (wr_en !== 1'b1 || wr_addr !== 5'd12 || pending[11] !== 1'b1) begin
          bad++; $display("FAIL mr_pre: got %b/%h/%b want 1/0c/1", wr_en, wr_addr, pending[11]);
        end
      end
      if (c == 3) begin
        total++; if (wr_en !== 1'b0 || pending !== 32'h0) begin bad++; $display("FAIL mr_post: got %b/%h want 0/0", wr_en, pending); end
        total++; if (cnt !== 16'h0 || s_cnt !== 4'h0) begin bad++; $display("FAIL mr_cnt: got %0d/%0d want 0", cnt, s_cnt); end
      end
      if (c == 4) begin
        total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++; $display("FAIL mr_ptr: got %b%b want 10", a_ready, b_ready); end
      end
      if (c == 5) begin
        total++; if (cnt !== 16'd1) begin bad++; $display("FAIL mr_cnt_after: got %0d want 1", cnt); end
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [73:0] s_obs, s_exp;
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 49) == 0);
      a_valid  = $urandom_range(0, 1) == 1;
      b_valid  = $urandom_range(0, 1) == 1;
      rsv_en   = $urandom_range(0, 4) < 2;
      a_addr   = 5'($urandom_range(0, 7));
      b_addr   = 5'($urandom_range(0, 7));
      rsv_addr = 5'($urandom_range(0, 7));
      rd_addr1 = 5'($urandom_range(0, 7));
      rd_addr2 = 5'($urandom_range(0, 31));
      a_data   = $urandom;
      b_data   = $urandom;
      @(negedge clk);
      total++; if (a_ready !== win_a() || b_ready !== win_b()) begin
        bad++; $display("FAIL rnd_grant c%0d: got %b%b want %b%b", c, a_ready, b_ready, win_a(), win_b());
      end
      total++; if (wr_en !== m_wr_en || wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
        bad++; $display("FAIL rnd_wr c%0d: got %b/%h/%h want %b/%h/%h", c, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data);
      end
      total++; if (pending !== m_pend_vec()) begin bad++; $display("FAIL rnd_pending c%0d: got %h want %h", c, pending, m_pend_vec()); end
      total++; if (busy1 !== m_pend[rd_addr1] || busy2 !== m_pend[rd_addr2]) begin
        bad++; $display("FAIL rnd_busy c%0d: got %b%b want %b%b", c, busy1, busy2, m_pend[rd_addr1], m_pend[rd_addr2]);
      end
      total++; if (cnt !== 16'(m_cnt_sat(65535)) || s_cnt !== 4'(m_cnt_sat(15))) begin
        bad++; $display("FAIL rnd_cnt c%0d: got %0d/%0d want %0d/%0d", c, cnt, s_cnt, m_cnt_sat(65535), m_cnt_sat(15));
      end
      total++; if (rf_read(rd_addr1) !== m_rf[rd_addr1]) begin
        bad++; $display("FAIL rnd_rf_read c%0d: got %h want %h", c, rf_read(rd_addr1), m_rf[rd_addr1]);
      end
      s_obs = {s_a_ready, s_b_ready, s_wr_en, s_busy1, s_busy2, s_wr_addr, s_wr_data, s_pending};
      s_exp = {win_a(), win_b(), m_wr_en, m_pend[rd_addr1], m_pend[rd_addr2], m_wr_addr, m_wr_data, m_pend_vec()};
      total++; if (s_obs !== s_exp) begin bad++; $display("FAIL rnd_sat_inst c%0d: got %h want %h", c, s_obs, s_exp); end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      rf[i]   = 32'h0;
      m_rf[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
    m_last_a = 1'b0; m_cnt = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; rsv_en = 1'b0;
    a_addr = '0; b_addr = '0; rsv_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
    a_data = '0; b_data = '0;
    #1;
    test_reset();
    test_single_write();
    test_contention();
    test_reg0();
    test_set_wins();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
